// File: rtl/sign_extd16.sv
// Registered immediate extender: sign/zero/branch/upper widening of a field.
// Optional SIGN_EXTD_COMB_OUT_EN adds the unregistered data_out_comb port.
module sign_extd16 #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       mode,
`ifdef SIGN_EXTD_COMB_OUT_EN
    output logic [OUT_W-1:0] data_out_comb,
`endif
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    output logic             is_neg
);

    localparam int EXT_W = OUT_W - IN_W;

    generate
        if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_param
            $error("sign_extd16: IN_W must be in 2..OUT_W-1");
        end
    endgenerate

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_result;

    assign w_sext = {{EXT_W{data_in[IN_W-1]}}, data_in};
    assign w_zext = {{EXT_W{1'b0}}, data_in};

    always_comb begin
        w_result = w_sext;
        unique case (mode)
            2'b00: w_result = w_sext;
            2'b01: w_result = w_zext;
            2'b10: w_result = {w_sext[OUT_W-2:0], 1'b0};
            2'b11: w_result = {data_in, {EXT_W{1'b0}}};
            default: w_result = w_sext;
        endcase
    end

`ifdef SIGN_EXTD_COMB_OUT_EN
    assign data_out_comb = w_result;
`endif

    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic             r_neg;

    // Payload holds on idle cycles; only the valid flag tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= w_result;
                r_neg  <= data_in[IN_W-1];
            end
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign is_neg    = r_neg;

endmodule

// File: tb/tb_sign_extd16.sv
// Self-checking bench for sign_extd16: directed and random steps
// against an arithmetic reference model.
module tb_sign_extd16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  data_in;
    logic [1:0]  mode;
    logic [15:0] data_out;
    logic        out_valid;
    logic        is_neg;
`ifdef SIGN_EXTD_COMB_OUT_EN
    logic [15:0] data_out_comb;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] m_data = 16'h0000;
    logic        m_neg  = 1'b0;

    sign_extd16 #(.IN_W(8), .OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .mode      (mode),
`ifdef SIGN_EXTD_COMB_OUT_EN
        .data_out_comb (data_out_comb),
`endif
        .data_out  (data_out),
        .out_valid (out_valid),
        .is_neg    (is_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input int d, input int m);
        int s;
        int r;
        s = (d >= 128) ? d - 256 : d;
        case (m)
            0:       r = s;
            1:       r = d;
            2:       r = s * 2;
            default: r = d * 256;
        endcase
        return 16'(r & 32'hFFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d,
                        input logic [1:0] m);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        mode     = m;
        if (v) begin
            m_data = model(int'(d), int'(m));
            m_neg  = d[7];
        end
        @(posedge clk);
        #1;
        chk($sformatf("valid d=%h m=%0d", d, m), 32'(out_valid), 32'(v));
        chk($sformatf("data d=%h m=%0d", d, m), 32'(data_out), 32'(m_data));
        chk($sformatf("neg d=%h m=%0d", d, m), 32'(is_neg), 32'(m_neg));
    endtask

    logic [7:0] seq [8];
    logic [7:0] bnd [3];

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = 8'h00;
        mode     = 2'b00;
        seq = '{8'h00, 8'h01, 8'h12, 8'h43, 8'h11, 8'h17, 8'hA9, 8'h8F};
        bnd = '{8'h7F, 8'h80, 8'hFF};
        #2;
        chk("reset data", 32'(data_out), 32'h0);
        chk("reset valid", 32'(out_valid), 32'h0);
        chk("reset neg", 32'(is_neg), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (seq[i]) step(1'b1, seq[i], 2'b00);
        chk("seq last literal", 32'(data_out), 32'hFF8F);

        step(1'b1, 8'hA9, 2'b01);
        chk("zext literal", 32'(data_out), 32'h00A9);
        step(1'b1, 8'h8F, 2'b10);
        chk("branch neg literal", 32'(data_out), 32'hFF1E);
        step(1'b1, 8'h43, 2'b10);
        chk("branch pos literal", 32'(data_out), 32'h0086);
        step(1'b1, 8'h43, 2'b11);
        chk("upper literal", 32'(data_out), 32'h4300);

        step(1'b1, 8'h8F, 2'b00);
        step(1'b0, 8'h12, 2'b00);
        chk("gate hold literal", 32'(data_out), 32'hFF8F);

        foreach (bnd[i]) step(1'b1, bnd[i], 2'b00);
        chk("bnd FF literal", 32'(data_out), 32'hFFFF);
        for (int i = 0; i < 8; i++)
            step(1'b1, bnd[i % 3], 2'(i));

`ifdef SIGN_EXTD_COMB_OUT_EN
        @(negedge clk);
        data_in = 8'hA9;
        mode    = 2'b00;
        #1;
        chk("comb same cycle", 32'(data_out_comb), 32'hFFA9);
`endif

        step(1'b1, 8'hC3, 2'b11);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset data", 32'(data_out), 32'h0);
        chk("midreset valid", 32'(out_valid), 32'h0);
        chk("midreset neg", 32'(is_neg), 32'h0);
`ifdef SIGN_EXTD_COMB_OUT_EN
        data_in = 8'hA9;
        mode    = 2'b00;
        #1;
        chk("comb in reset", 32'(data_out_comb), 32'hFFA9);
`endif
        @(posedge clk);
        #1;
        chk("held in reset", 32'(data_out), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_data = 16'h0000;
        m_neg  = 1'b0;

        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), 8'($urandom),
                 2'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
